// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: RV32I width
// codes, writeback result-source encodings, FSM states and the access
// legality rule.
package rv32i_mem_pkg;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_e;

    // A memory op is legal when it is exactly one of load/store, uses a
    // width code defined for that direction, and is naturally aligned.
    function automatic logic access_legal(input logic       is_load,
                                          input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        if (is_load && !is_store) begin
            case (f3)
                F3_BYTE, F3_BYTE_U: ok = 1'b1;
                F3_HALF, F3_HALF_U: ok = ~addr_lo[0];
                F3_WORD:            ok = (addr_lo == 2'b00);
                default:            ok = 1'b0;
            endcase
        end else if (is_store && !is_load) begin
            case (f3)
                F3_BYTE: ok = 1'b1;
                F3_HALF: ok = ~addr_lo[0];
                F3_WORD: ok = (addr_lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory valid/ack port. The LSU is the master; the memory answers
// with ack and, for loads, the raw word in the same cycle.
interface mem_stage_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_align_unit.sv
// Byte-lane steering: builds store byte enables and replicated store data,
// and pulls the addressed byte/half out of a loaded word with sign or zero
// extension.
module mem_align_unit
    import rv32i_mem_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Store side: replicate the narrow datum on every lane and enable only
    // the lanes the address selects.
    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
        case (i_st_funct3)
            F3_BYTE: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            F3_HALF: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_be    = 4'b1111;
                o_st_wdata = i_st_data;
            end
        endcase
    end

    // Load side: pick the addressed byte and half-word lanes.
    always_comb begin
        w_ld_byte = i_ld_rdata[7:0];
        case (i_ld_addr_lo)
            2'b00: w_ld_byte = i_ld_rdata[7:0];
            2'b01: w_ld_byte = i_ld_rdata[15:8];
            2'b10: w_ld_byte = i_ld_rdata[23:16];
            2'b11: w_ld_byte = i_ld_rdata[31:24];
        endcase
        w_ld_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    end

    // Load side: extend the selected lane to 32 bits.
    always_comb begin
        o_ld_data = i_ld_rdata;
        case (i_ld_funct3)
            F3_BYTE:   o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_BYTE_U: o_ld_data = {24'b0, w_ld_byte};
            F3_HALF:   o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            F3_HALF_U: o_ld_data = {16'b0, w_ld_half};
            default:   o_ld_data = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues aligned data-memory requests,
// stalls the pipeline while an access is outstanding, and registers the
// selected result into the memory-to-writeback boundary.
module mem_stage_lsu
    import rv32i_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_m,
    input  logic                   mem_read_m,
    input  logic                   mem_write_m,
    input  logic [2:0]             funct3_m,
    input  logic                   reg_write_m,
    input  logic [1:0]             result_src_m,
    input  logic [31:0]            alu_result_m,
    input  logic [31:0]            write_data_m,
    input  logic [31:0]            pc_plus4_m,
    input  logic [4:0]             rd_m,
    mem_stage_lsu_if.master        dmem,
    output logic                   stall_m,
    output logic [31:0]            result_w,
    output logic [4:0]             rd_w,
    output logic                   reg_write_w,
    output logic                   valid_w,
    output logic                   fault_w
);

    lsu_state_e  r_state;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic [31:0] r_result_w;
    logic [4:0]  r_rd_w;
    logic        r_reg_write_w;
    logic        r_valid_w;
    logic        r_fault_w;

    logic        w_mem_op;
    logic        w_legal;
    logic        w_accept;
    logic        w_fault;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;
    logic [31:0] w_idle_result;

    assign w_mem_op = valid_m & (mem_read_m | mem_write_m);
    assign w_legal  = access_legal(mem_read_m, mem_write_m, funct3_m, alu_result_m[1:0]);
    assign w_accept = (r_state == ST_IDLE) & w_mem_op & w_legal;
    assign w_fault  = (r_state == ST_IDLE) & w_mem_op & ~w_legal;

    mem_align_unit u_align (
        .i_st_funct3  (funct3_m),
        .i_st_addr_lo (alu_result_m[1:0]),
        .i_st_data    (write_data_m),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_rdata   (dmem.rdata),
        .o_ld_data    (w_ld_data)
    );

    // Non-memory writeback value; the reserved encoding and a load-source
    // code without a memory op both fall back to the ALU result.
    always_comb begin
        w_idle_result = alu_result_m;
        if (result_src_m == RES_PC4) begin
            w_idle_result = pc_plus4_m;
        end
    end

    // Hold the pipeline on the accept cycle and on every BUSY cycle without
    // ack; the ack cycle releases so M advances on the completing edge.
    always_comb begin
        stall_m = 1'b0;
        if (rst_n) begin
            stall_m = w_accept | ((r_state == ST_BUSY) & ~dmem.ack);
        end
    end

    // Request/response FSM together with the registered writeback slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_funct3      <= '0;
            r_addr_lo     <= '0;
            r_rd          <= '0;
            r_reg_write   <= 1'b0;
            r_result_w    <= '0;
            r_rd_w        <= '0;
            r_reg_write_w <= 1'b0;
            r_valid_w     <= 1'b0;
            r_fault_w     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_fault_w <= 1'b0;
                    if (w_accept) begin
                        r_req         <= 1'b1;
                        r_we          <= mem_write_m;
                        r_addr        <= {alu_result_m[31:2], 2'b00};
                        r_be          <= mem_write_m ? w_st_be : 4'b1111;
                        r_wdata       <= mem_write_m ? w_st_wdata : 32'b0;
                        r_funct3      <= funct3_m;
                        r_addr_lo     <= alu_result_m[1:0];
                        r_rd          <= rd_m;
                        r_reg_write   <= reg_write_m;
                        r_valid_w     <= 1'b0;
                        r_reg_write_w <= 1'b0;
                        r_state       <= ST_BUSY;
                    end else if (w_fault) begin
                        r_result_w    <= alu_result_m;
                        r_rd_w        <= rd_m;
                        r_reg_write_w <= 1'b0;
                        r_valid_w     <= 1'b1;
                        r_fault_w     <= 1'b1;
                    end else begin
                        r_result_w    <= w_idle_result;
                        r_rd_w        <= rd_m;
                        r_reg_write_w <= reg_write_m & valid_m;
                        r_valid_w     <= valid_m;
                    end
                end
                ST_BUSY: begin
                    r_fault_w <= 1'b0;
                    if (dmem.ack) begin
                        r_req         <= 1'b0;
                        r_result_w    <= r_we ? 32'b0 : w_ld_data;
                        r_rd_w        <= r_rd;
                        r_reg_write_w <= r_reg_write & ~r_we;
                        r_valid_w     <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_valid_w     <= 1'b0;
                        r_reg_write_w <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign dmem.req    = r_req;
    assign dmem.we     = r_we;
    assign dmem.addr   = r_addr;
    assign dmem.be     = r_be;
    assign dmem.wdata  = r_wdata;
    assign result_w    = r_result_w;
    assign rd_w        = r_rd_w;
    assign reg_write_w = r_reg_write_w;
    assign valid_w     = r_valid_w;
    assign fault_w     = r_fault_w;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected writebacks are queued as
// instructions are driven and compared whenever the W slot retires.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        valid_m;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [2:0]  funct3_m;
    logic        reg_write_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [31:0] pc_plus4_m;
    logic [4:0]  rd_m;
    logic        stall_m;
    logic [31:0] result_w;
    logic [4:0]  rd_w;
    logic        reg_write_w;
    logic        valid_w;
    logic        fault_w;

    mem_stage_lsu_if dmemIf ();

    mem_stage_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_m      (valid_m),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .funct3_m     (funct3_m),
        .reg_write_m  (reg_write_m),
        .result_src_m (result_src_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .rd_m         (rd_m),
        .dmem         (dmemIf.master),
        .stall_m      (stall_m),
        .result_w     (result_w),
        .rd_w         (rd_w),
        .reg_write_w  (reg_write_w),
        .valid_w      (valid_w),
        .fault_w      (fault_w)
    );

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
        logic        fault;
        logic        checkResult;
    } wbExp_t;

    wbExp_t expQ[$];
    wbExp_t monExp;
    int     checkCount = 0;
    int     passCount  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every retirement must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid_w) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_retire: valid_w=1 rd_w=%0d, nothing expected", rd_w);
            end else begin
                monExp = expQ.pop_front();
                checkCount++;
                if (rd_w !== monExp.rd) $display("[TB] FAIL wb_rd: got %0d expected %0d", rd_w, monExp.rd);
                else passCount++;
                checkCount++;
                if (reg_write_w !== monExp.regWrite) $display("[TB] FAIL wb_reg_write (rd %0d): got %b expected %b", monExp.rd, reg_write_w, monExp.regWrite);
                else passCount++;
                checkCount++;
                if (fault_w !== monExp.fault) $display("[TB] FAIL wb_fault (rd %0d): got %b expected %b", monExp.rd, fault_w, monExp.fault);
                else passCount++;
                if (monExp.checkResult) begin
                    checkCount++;
                    if (result_w !== monExp.result) $display("[TB] FAIL wb_result (rd %0d): got %h expected %h", monExp.rd, result_w, monExp.result);
                    else passCount++;
                end
            end
        end
    end

    task automatic driveM(input logic v, input logic rdEn, input logic wrEn, input logic [2:0] f3,
                          input logic rw, input logic [1:0] src, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd);
        valid_m      = v;
        mem_read_m   = rdEn;
        mem_write_m  = wrEn;
        funct3_m     = f3;
        reg_write_m  = rw;
        result_src_m = src;
        alu_result_m = alu;
        write_data_m = wd;
        pc_plus4_m   = pc4;
        rd_m         = rd;
    endtask

    task automatic setIdle();
        driveM(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic pushExp(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                           input logic flt, input logic chk);
        wbExp_t e;
        e.result = res; e.rd = rd; e.regWrite = rw; e.fault = flt; e.checkResult = chk;
        expQ.push_back(e);
    endtask

    // Runs one memory access whose M inputs are already driven; acks after
    // waitCycles BUSY cycles and reports what the port showed.
    task automatic memTxn(input int waitCycles, input logic [31:0] rdata, output int stalls,
                          output logic req, output logic we, output logic [31:0] addr,
                          output logic [31:0] wdata, output logic [3:0] be);
        stalls = 0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        @(negedge clk);
        if (stall_m) stalls++;
        for (int i = 0; i <= waitCycles; i++) begin
            @(posedge clk); #1;
            if (i == waitCycles) begin
                dmemIf.ack   = 1'b1;
                dmemIf.rdata = rdata;
            end
            @(negedge clk);
            if (i == 0) begin
                req = dmemIf.req; we = dmemIf.we; addr = dmemIf.addr;
                wdata = dmemIf.wdata; be = dmemIf.be;
            end
            if (stall_m) stalls++;
        end
        @(posedge clk); #1;
        dmemIf.ack   = 1'b0;
        dmemIf.rdata = 32'h0;
        setIdle();
    endtask

    task automatic test_reset();
        #2;
        checkCount++;
        if ({valid_w, reg_write_w, fault_w, stall_m} !== 4'b0000)
            $display("[TB] FAIL reset_flags: valid/regwr/fault/stall got %b expected 0000", {valid_w, reg_write_w, fault_w, stall_m});
        else passCount++;
        checkCount++;
        if ({result_w, rd_w} !== 37'h0) $display("[TB] FAIL reset_wb: result %h rd %0d expected 0", result_w, rd_w);
        else passCount++;
        checkCount++;
        if ({dmemIf.req, dmemIf.we, dmemIf.be, dmemIf.addr, dmemIf.wdata} !== 70'h0)
            $display("[TB] FAIL reset_dmem: req %b we %b be %b addr %h wdata %h expected 0", dmemIf.req, dmemIf.we, dmemIf.be, dmemIf.addr, dmemIf.wdata);
        else passCount++;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_back_to_back();
        driveM(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd7);
        pushExp(32'h55, 5'd7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkCount++;
        if (stall_m !== 1'b0) $display("[TB] FAIL add_stall: got %b expected 0", stall_m); else passCount++;
        @(posedge clk); #1;
        driveM(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'b10, 32'h2000, 32'h0, 32'h1004, 5'd1);
        pushExp(32'h1004, 5'd1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkCount++;
        if (stall_m !== 1'b0) $display("[TB] FAIL jal_stall: got %b expected 0", stall_m); else passCount++;
        @(posedge clk); #1;
        driveM(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'b11, 32'h99, 32'h0, 32'h4444, 5'd9);
        pushExp(32'h99, 5'd9, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        driveM(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 32'h66, 32'h0, 32'h0, 5'd10);
        @(posedge clk); #1;
        setIdle();
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        int stalls; logic req, we; logic [31:0] addr, wdata; logic [3:0] be;
        driveM(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 2'b01, 32'h100, 32'h0, 32'h0, 5'd5);
        pushExp(32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b1);
        memTxn(2, 32'hDEADBEEF, stalls, req, we, addr, wdata, be);
        checkCount++;
        if (stalls != 3) $display("[TB] FAIL lw_stall_cycles: got %0d expected 3", stalls); else passCount++;
        checkCount++;
        if ({req, we, be, addr} !== {1'b1, 1'b0, 4'b1111, 32'h100})
            $display("[TB] FAIL lw_request: req %b we %b be %b addr %h expected 1 0 1111 00000100", req, we, be, addr);
        else passCount++;

        driveM(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 2'b01, 32'h103, 32'h0, 32'h0, 5'd6);
        pushExp(32'hFFFFFF80, 5'd6, 1'b1, 1'b0, 1'b1);
        memTxn(1, 32'h80FF0000, stalls, req, we, addr, wdata, be);
        checkCount++;
        if (stalls != 2) $display("[TB] FAIL lb_stall_cycles: got %0d expected 2", stalls); else passCount++;
        checkCount++;
        if (addr !== 32'h100) $display("[TB] FAIL lb_addr: got %h expected 00000100", addr); else passCount++;

        driveM(1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 2'b01, 32'h103, 32'h0, 32'h0, 5'd8);
        pushExp(32'h00000080, 5'd8, 1'b1, 1'b0, 1'b1);
        memTxn(0, 32'h80FF0000, stalls, req, we, addr, wdata, be);
        checkCount++;
        if (stalls != 1) $display("[TB] FAIL lbu_stall_cycles: got %0d expected 1", stalls); else passCount++;

        driveM(1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 2'b01, 32'h102, 32'h0, 32'h0, 5'd11);
        pushExp(32'hFFFF8001, 5'd11, 1'b1, 1'b0, 1'b1);
        memTxn(0, 32'h80011234, stalls, req, we, addr, wdata, be);
        driveM(1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 2'b01, 32'h100, 32'h0, 32'h0, 5'd12);
        pushExp(32'h0000F00D, 5'd12, 1'b1, 1'b0, 1'b1);
        memTxn(0, 32'h1234F00D, stalls, req, we, addr, wdata, be);
        @(posedge clk); #1;
    endtask

    task automatic test_stores();
        int stalls; logic req, we; logic [31:0] addr, wdata; logic [3:0] be;
        driveM(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 2'b00, 32'h202, 32'h1234ABCD, 32'h0, 5'd3);
        pushExp(32'h0, 5'd3, 1'b0, 1'b0, 1'b0);
        memTxn(0, 32'h0, stalls, req, we, addr, wdata, be);
        checkCount++;
        if (stalls != 1) $display("[TB] FAIL sh_stall_cycles: got %0d expected 1", stalls); else passCount++;
        checkCount++;
        if ({req, we, be, addr, wdata} !== {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCDABCD})
            $display("[TB] FAIL sh_request: req %b we %b be %b addr %h wdata %h expected 1 1 1100 00000200 abcdabcd", req, we, be, addr, wdata);
        else passCount++;

        driveM(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 2'b00, 32'h201, 32'h000000A5, 32'h0, 5'd0);
        pushExp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        memTxn(1, 32'h0, stalls, req, we, addr, wdata, be);
        checkCount++;
        if ({be, addr, wdata} !== {4'b0010, 32'h200, 32'hA5A5A5A5})
            $display("[TB] FAIL sb_request: be %b addr %h wdata %h expected 0010 00000200 a5a5a5a5", be, addr, wdata);
        else passCount++;

        driveM(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 2'b00, 32'h300, 32'hCAFEF00D, 32'h0, 5'd0);
        pushExp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        memTxn(3, 32'h0, stalls, req, we, addr, wdata, be);
        checkCount++;
        if (stalls != 4) $display("[TB] FAIL sw_stall_cycles: got %0d expected 4", stalls); else passCount++;
        checkCount++;
        if ({we, be, addr, wdata} !== {1'b1, 4'b1111, 32'h300, 32'hCAFEF00D})
            $display("[TB] FAIL sw_request: we %b be %b addr %h wdata %h expected 1 1111 00000300 cafef00d", we, be, addr, wdata);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_faults();
        logic [2:0]  f3Tab [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
        logic [31:0] adTab [6] = '{32'h101, 32'h103, 32'h302, 32'h100, 32'h100, 32'h100};
        logic        rdTab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        wrTab [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            driveM(1'b1, rdTab[i], wrTab[i], f3Tab[i], 1'b1, 2'b01, adTab[i], 32'h77, 32'h0, 5'(20 + i));
            pushExp(32'h0, 5'(20 + i), 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkCount++;
            if ({stall_m, dmemIf.req} !== 2'b00)
                $display("[TB] FAIL fault_no_access[%0d]: stall %b req %b expected 0 0", i, stall_m, dmemIf.req);
            else passCount++;
            @(posedge clk); #1;
        end
        setIdle();
        @(posedge clk); #1;
        @(negedge clk);
        checkCount++;
        if ({fault_w, valid_w} !== 2'b00) $display("[TB] FAIL fault_single_cycle: fault %b valid %b expected 0 0", fault_w, valid_w);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_ack_idle();
        dmemIf.ack   = 1'b1;
        dmemIf.rdata = 32'hFFFFFFFF;
        driveM(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 32'h33, 32'h0, 32'h0, 5'd2);
        pushExp(32'h33, 5'd2, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkCount++;
        if ({stall_m, dmemIf.req} !== 2'b00) $display("[TB] FAIL idle_ack: stall %b req %b expected 0 0", stall_m, dmemIf.req);
        else passCount++;
        @(posedge clk); #1;
        setIdle();
        @(posedge clk); #1;
        dmemIf.ack   = 1'b0;
        dmemIf.rdata = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_busy();
        driveM(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 2'b01, 32'h100, 32'h0, 32'h0, 5'd5);
        @(posedge clk); #1;
        @(negedge clk);
        checkCount++;
        if (dmemIf.req !== 1'b1) $display("[TB] FAIL busy_req_before_reset: got %b expected 1", dmemIf.req);
        else passCount++;
        #1 rst_n = 1'b0;
        #1;
        checkCount++;
        if ({dmemIf.req, dmemIf.we, dmemIf.be, dmemIf.addr, dmemIf.wdata, stall_m} !== 71'h0)
            $display("[TB] FAIL busy_reset_dmem: req %b be %b addr %h stall %b expected 0", dmemIf.req, dmemIf.be, dmemIf.addr, stall_m);
        else passCount++;
        checkCount++;
        if ({valid_w, reg_write_w, fault_w, rd_w, result_w} !== 40'h0)
            $display("[TB] FAIL busy_reset_wb: valid %b regwr %b rd %0d result %h expected 0", valid_w, reg_write_w, rd_w, result_w);
        else passCount++;
        setIdle();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        driveM(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 5'd3);
        pushExp(32'h77, 5'd3, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkCount++;
        if (stall_m !== 1'b0) $display("[TB] FAIL post_reset_stall: got %b expected 0", stall_m); else passCount++;
        @(posedge clk); #1;
        setIdle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        dmemIf.ack   = 1'b0;
        dmemIf.rdata = 32'h0;
        setIdle();
        test_reset();
        test_alu_back_to_back();
        test_loads();
        test_stores();
        test_faults();
        test_ack_idle();
        test_reset_busy();
        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clk);
        checkCount++;
        if (expQ.size() != 0) $display("[TB] FAIL drain: %0d retirements outstanding, expected 0", expQ.size());
        else passCount++;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the pipelined RV32I core. Consumes the execute-to-memory pipeline register outputs, drives a valid/ack data-memory port with byte-lane alignment, and stalls the pipeline while an access is outstanding. Registers the selected result into the memory-to-writeback boundary for the register-file write.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.

- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- valid_m  in  1  M-stage slot holds a real instruction
- mem_read_m / mem_write_m  in  1 each  load / store
- funct3_m  in  3  RV32I width code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- reg_write_m  in  1  instruction writes rd
- result_src_m  in  2  00 ALU, 01 load data, 10 pc+4; 11 reserved, treated as 00
- alu_result_m  in  32  effective address or ALU result
- write_data_m  in  32  store data (rs2)
- pc_plus4_m  in  32  link value
- rd_m  in  5  destination register
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address (bits [1:0] = 0)
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid same cycle
- dmem_rdata  in  32  raw load word
- stall_m  out  1  upstream must hold M inputs and freeze F/D/E
- result_w  out  32  writeback value
- rd_w  out  5  writeback register
- reg_write_w  out  1  register-file write enable
- valid_w  out  1  W slot holds a retired instruction
- fault_w  out  1  misaligned/illegal access retired (one cycle)

## Operation
- FSM states IDLE, BUSY. Reset -> IDLE.
- IDLE, valid_m=0 or no memory op: result_w loaded per result_src_m, rd_w=rd_m, reg_write_w=reg_write_m&valid_m, valid_w=valid_m; no stall.
- IDLE, legal memory op: latch dmem_addr/we/be/wdata/funct3/rd/reg_write into request registers, -> BUSY; W loads bubble (valid_w=0, reg_write_w=0); stall_m=1.
- BUSY: dmem_req=1, request registers stable. No ack: stall_m=1, W bubble. Ack: W loads load result (or store retirement with reg_write_w=0), valid_w=1, stall_m=0, -> IDLE.
- Legality: LW/SW need addr[1:0]=00; LH/LHU/SH need addr[0]=0; funct3 not listed above, or mem_read_m&mem_write_m, is illegal. Illegal/misaligned: no request, no stall, W gets valid_w=1, reg_write_w=0, fault_w=1.
- Store lanes: SB be=0001<<addr[1:0], wdata={4{byte}}; SH be=0011 (addr[1]=0) or 1100, wdata={2{half}}; SW be=1111.
- Loads: dmem_be=1111, dmem_we=0; byte/half selected by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- dmem_ack outside BUSY ignored.

## Timing
- Reset (async, immediate): dmem_req/we/be/addr/wdata=0, stall_m=0, result_w=0, rd_w=0, reg_write_w=0, valid_w=0, fault_w=0, state IDLE. Reset mid-BUSY drops dmem_req without waiting for ack; the in-flight access is discarded.
- Non-memory and faulting instructions: 1-cycle latency, M inputs sampled -> W valid after next edge.
- Memory access: cycle N accept (stall), cycle N+1 first dmem_req; ack in cycle N+k gives W valid after that edge; stall_m high for cycles N..N+k-1, low in the ack cycle so M advances on the same edge. Minimum 2 cycles.
- stall_m is combinational from state, M inputs and dmem_ack.
- fault_w, valid_w are single-cycle per retired instruction.

## Structure
- Shared package rv32i_mem_pkg: funct3 width codes, result_src encodings, FSM state enum.
- One sub-module mem_align_unit: combinational store lane/byte-enable generation and load extraction/extension; instantiated once.

## Test plan
- Rst_n low during BUSY with dmem_req=1 -> all outputs 0 immediately; after release, first ALU op retires normally.
- LW addr 0x100, ack after 2 wait cycles with rdata 0xDEADBEEF, rd 5 -> dmem_addr 0x100, be 1111, we 0; stall_m high 3 cycles; result_w 0xDEADBEEF, rd_w 5, reg_write_w 1.
- LB addr 0x103, rdata 0x80FF0000 -> result_w 0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, write_data 0x1234ABCD, ack immediate -> dmem_addr 0x200, be 1100, wdata 0xABCDABCD, we 1; reg_write_w 0, valid_w 1.
- LW addr 0x101 -> no dmem_req, stall_m 0, fault_w 1 one cycle, reg_write_w 0.
- ADD result 0x55 rd 7, then JAL result_src 10 pc_plus4 0x1004 rd 1 back-to-back -> W shows 0x55/7 then 0x1004/1, no stall.
